// File: rtl/manchester_frame_rx.sv
// Manchester receiver: samples sig_in once per recovered half-bit, pairs halves into bits,
// hunts for SYNC_WORD and deframes FRAME_BYTES bytes MSB-first with strobed outputs.
module manchester_frame_rx #(
    parameter logic [7:0]  SYNC_WORD   = 8'hA5,
    parameter int          FRAME_BYTES = 4,
    parameter logic [31:0] TIMEOUT     = 32'd2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig_in,
    input  logic       sync_clk,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_start,
    output logic       frame_done,
    output logic       code_err,
    output logic       locked
);

    typedef enum logic {HUNT, DATA} state_t;

    state_t      state;
    logic        sig_s1, sig_s2, sync_s1, sync_s2;
    logic        phase, first;
    // Only the newest 7 bits are kept; the 8th comes from the bit being decoded.
    logic [6:0]  hunt_sr, rx_sr;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [31:0] idle_cnt;

    logic       half_tick, sample;
    logic [7:0] hunt_next, rx_next;
    logic [8:0] byte_nxt;

    assign half_tick = sync_s1 & ~sync_s2;
    assign sample    = sig_s2;
    assign hunt_next = {hunt_sr, first};
    assign rx_next   = {rx_sr, first};
    assign byte_nxt  = {1'b0, byte_cnt} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_s1      <= 1'b0;
            sig_s2      <= 1'b0;
            sync_s1     <= 1'b0;
            sync_s2     <= 1'b0;
            state       <= HUNT;
            phase       <= 1'b0;
            first       <= 1'b0;
            hunt_sr     <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            code_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            sig_s1      <= sig_in;
            sig_s2      <= sig_s1;
            sync_s1     <= sync_clk;
            sync_s2     <= sync_s1;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            code_err    <= 1'b0;

            if (half_tick) begin
                idle_cnt <= '0;
                if (!phase) begin
                    first <= sample;
                    phase <= 1'b1;
                end else if (first == sample) begin
                    // Invalid pair: slip by one half-bit, keeping this sample as the new first half.
                    code_err <= 1'b1;
                    first    <= sample;
                    if (state == DATA) begin
                        state   <= HUNT;
                        locked  <= 1'b0;
                        hunt_sr <= '0;
                        rx_sr   <= '0;
                    end
                end else begin
                    phase <= 1'b0;
                    if (state == HUNT) begin
                        hunt_sr <= hunt_next[6:0];
                        if (hunt_next == SYNC_WORD) begin
                            state       <= DATA;
                            locked      <= 1'b1;
                            frame_start <= 1'b1;
                            bit_cnt     <= '0;
                            byte_cnt    <= '0;
                        end
                    end else begin
                        rx_sr <= rx_next[6:0];
                        if (bit_cnt == 3'd7) begin
                            bit_cnt    <= '0;
                            data_out   <= rx_next;
                            data_valid <= 1'b1;
                            if (byte_nxt == 9'(FRAME_BYTES)) begin
                                frame_done <= 1'b1;
                                state      <= HUNT;
                                locked     <= 1'b0;
                                hunt_sr    <= '0;
                                byte_cnt   <= '0;
                            end else begin
                                byte_cnt <= byte_nxt[7:0];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
            end else if (idle_cnt == TIMEOUT - 32'd1) begin
                // Line went quiet: drop lock silently and restart pairing from scratch.
                state   <= HUNT;
                phase   <= 1'b0;
                hunt_sr <= '0;
                rx_sr   <= '0;
                locked  <= 1'b0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_manchester_frame_rx.sv
// Bench for manchester_frame_rx: table-driven payload with a byte scoreboard,
// plus hand-written sequences for slip, abort, timeout, reset and partial sync match.
module tb_manchester_frame_rx;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sig_in = 1'b0;
    logic       sync_clk = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, frame_start, frame_done, code_err, locked;

    manchester_frame_rx #(
        .SYNC_WORD  (8'hA5),
        .FRAME_BYTES(4),
        .TIMEOUT    (32'(TO))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .sync_clk   (sync_clk),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .code_err   (code_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       done;
    } vec_t;

    vec_t tbl[4];
    vec_t sb[$];

    int tests = 0;
    int fails = 0;
    int fs_cnt = 0, err_cnt = 0, done_cnt = 0, valid_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_start) fs_cnt++;
            if (code_err) err_cnt++;
            if (frame_done) begin
                done_cnt++;
                chk("done_with_valid", 32'(data_valid), 32'd1);
            end
            if (data_valid) begin
                valid_cnt++;
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    vec_t e;
                    e = sb.pop_front();
                    chk("byte", 32'(data_out), 32'(e.d));
                    chk("frame_done_flag", 32'(frame_done), 32'(e.done));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_half(input logic b);
        sig_in = b;
        idle(2);
        sync_clk = 1'b1;
        idle(3);
        sync_clk = 1'b0;
        idle(3);
    endtask

    task automatic send_bit(input logic b);
        send_half(b);
        send_half(~b);
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(d, 8);
    endtask

    task automatic send_payload();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(tbl[i]);
            send_byte(tbl[i].d);
        end
    endtask

    task automatic clr_counts();
        fs_cnt = 0; err_cnt = 0; done_cnt = 0; valid_cnt = 0;
    endtask

    task automatic check_frame_ok(input string tag);
        idle(4);
        chk({tag, "_frame_start"}, 32'(fs_cnt), 32'd1);
        chk({tag, "_frame_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_valids"}, 32'(valid_cnt), 32'd4);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_unlocked"}, 32'(locked), 32'd0);
    endtask

    initial begin
        tbl[0] = '{8'h3C, 1'b0};
        tbl[1] = '{8'h00, 1'b0};
        tbl[2] = '{8'hFF, 1'b0};
        tbl[3] = '{8'h81, 1'b1};

        // Reset state
        idle(3);
        #1;
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_pulses", 32'({data_valid, frame_start, frame_done, code_err}), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(TO + 20);

        // T1: clean frame
        clr_counts();
        send_byte(8'hA5);
        chk("t1_locked", 32'(locked), 32'd1);
        send_payload();
        check_frame_ok("t1");
        chk("t1_no_err", 32'(err_cnt), 32'd0);
        idle(TO + 20);
        chk("t1_data_hold", 32'(data_out), 32'h81);

        // T2: extra half-bit ahead of a 0xFF preamble forces one slip
        clr_counts();
        send_half(1'b1);
        send_byte(8'hFF);
        send_byte(8'hA5);
        send_payload();
        check_frame_ok("t2");
        chk("t2_one_err", 32'(err_cnt), 32'd1);
        idle(TO + 20);

        // T6: partial match 0xA4 must not lock
        clr_counts();
        send_byte(8'hA4);
        chk("t6_no_false_start", 32'(fs_cnt), 32'd0);
        chk("t6_no_false_lock", 32'(locked), 32'd0);
        send_byte(8'hA5);
        chk("t6_start_after_a5", 32'(fs_cnt), 32'd1);
        send_payload();
        check_frame_ok("t6");
        idle(TO + 20);

        // T3: pair 11 in the middle of byte 2 aborts the frame
        clr_counts();
        send_byte(8'hA5);
        sb.push_back(tbl[0]);
        send_byte(tbl[0].d);
        send_bits(8'h55, 4);
        send_half(1'b1);
        send_half(1'b1);
        idle(4);
        chk("t3_err", 32'(err_cnt), 32'd1);
        chk("t3_unlocked", 32'(locked), 32'd0);
        chk("t3_one_valid", 32'(valid_cnt), 32'd1);
        chk("t3_no_done", 32'(done_cnt), 32'd0);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        idle(TO + 20);

        // T4: sync_clk stops mid-frame, lock drops at the timeout
        clr_counts();
        send_byte(8'hA5);
        sb.push_back(tbl[0]);
        send_byte(tbl[0].d);
        send_bits(8'hC0, 2);
        chk("t4_locked_before", 32'(locked), 32'd1);
        idle(TO - 10);
        chk("t4_still_locked", 32'(locked), 32'd1);
        idle(15);
        chk("t4_timeout_unlock", 32'(locked), 32'd0);
        chk("t4_no_pulses", 32'(err_cnt + done_cnt), 32'd0);
        idle(TO);
        clr_counts();
        send_byte(8'hA5);
        send_payload();
        check_frame_ok("t4");
        idle(TO + 20);

        // T5: reset mid-byte-3
        clr_counts();
        send_byte(8'hA5);
        sb.push_back(tbl[0]);
        send_byte(tbl[0].d);
        sb.push_back(tbl[1]);
        send_byte(tbl[1].d);
        send_bits(8'hFF, 3);
        chk("t5_locked_before", 32'(locked), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data_out", 32'(data_out), 32'd0);
        chk("t5_rst_locked", 32'(locked), 32'd0);
        chk("t5_rst_pulses", 32'({data_valid, frame_start, frame_done, code_err}), 32'd0);
        chk("t5_two_valids", 32'(valid_cnt), 32'd2);
        idle(3);
        rst_n = 1'b1;
        idle(5);
        clr_counts();
        send_byte(8'hA5);
        send_payload();
        check_frame_ok("t5");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
